// File: rtl/wb_initiator.sv
// wb_initiator: single-outstanding Wishbone classic initiator with cmd/rsp handshakes and ack timeout
module wb_initiator #(
    parameter int WB_ADR_WIDTH   = 8,
    parameter int WB_DAT_WIDTH   = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [WB_ADR_WIDTH-1:0] cmd_adr_i,
    input  logic [WB_DAT_WIDTH-1:0] cmd_dat_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [WB_DAT_WIDTH-1:0] rsp_dat_o,
    output logic                    rsp_err_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    output logic                    wb_we_o,
    output logic [WB_ADR_WIDTH-1:0] wb_adr_o,
    output logic [WB_DAT_WIDTH-1:0] wb_dat_o,
    input  logic [WB_DAT_WIDTH-1:0] wb_dat_i,
    input  logic                    wb_ack_i
);
    localparam logic [1:0]  IDLE    = 2'd0;
    localparam logic [1:0]  BUS     = 2'd1;
    localparam logic [1:0]  RESP    = 2'd2;
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [1:0]              state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    stb_q, stb_d;
    logic                    we_q, we_d;
    logic [WB_ADR_WIDTH-1:0] adr_q, adr_d;
    logic [WB_DAT_WIDTH-1:0] dat_q, dat_d;
    logic [WB_DAT_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
    logic                    rsp_err_q, rsp_err_d;

    assign cmd_ready_o = state_q == IDLE;
    assign rsp_valid_o = state_q == RESP;
    assign wb_cyc_o    = stb_q;
    assign wb_stb_o    = stb_q;
    assign wb_we_o     = we_q;
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_err_o   = rsp_err_q;

    // next state: accept a command, run the bus cycle until ack or timeout, hold the response until taken
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stb_d     = stb_q;
        we_d      = we_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            IDLE: if (cmd_valid_i) begin
                state_d = BUS;
                cnt_d   = '0;
                stb_d   = 1'b1;
                we_d    = cmd_we_i;
                adr_d   = cmd_adr_i;
                dat_d   = cmd_dat_i;
            end
            BUS: if (wb_ack_i) begin
                state_d   = RESP;
                stb_d     = 1'b0;
                rsp_err_d = 1'b0;
                rsp_dat_d = we_q ? '0 : wb_dat_i;
            end else if (cnt_q == TO_LAST) begin
                state_d   = RESP;
                stb_d     = 1'b0;
                rsp_err_d = 1'b1;
                rsp_dat_d = '0;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
            RESP: state_d = rsp_ready_i ? IDLE : RESP;
            default: begin
                state_d = IDLE;
                stb_d   = 1'b0;
            end
        endcase
    end

    // state registers; reset aborts any bus cycle and clears the response
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: randomized bench for wb_initiator against a transaction-level memory/timeout model
module tb_wb_initiator;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [7:0]  cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [31:0] rsp_dat;
    logic        wb_cyc, wb_stb, wb_we, wb_ack = 1'b0;
    logic [7:0]  wb_adr;
    logic [31:0] wb_dat_o, wb_dat_i = '0;

    logic [31:0] smem [256];
    logic [31:0] model [256];
    int          n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    wb_initiator #(.WB_ADR_WIDTH(8), .WB_DAT_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat), .rsp_err_o(rsp_err),
        .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
        .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // one command through the DUT; ack_at = strobe cycle in which the slave acks (0 = never)
    task automatic txn(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                       input int ack_at, input int rdly);
        int          n = 0;
        logic        bad = 1'b0;
        logic        hit = ack_at >= 1 && ack_at <= T;
        int          exp_n = hit ? ack_at : T;
        logic [31:0] exp_d = (!hit || we) ? 32'h0 : model[adr];
        logic [31:0] held_d;
        logic        held_e;
        if (hit && we) model[adr] = dat;
        @(negedge clk);
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat;
        @(negedge clk);
        cmd_valid = 1'b0; cmd_dat = $urandom; cmd_adr = 8'($urandom); cmd_we = 1'($urandom);
        while (wb_stb && n < 100) begin
            n++;
            if (wb_cyc !== wb_stb || wb_we !== we || wb_adr !== adr || wb_dat_o !== dat ||
                rsp_valid || cmd_ready) bad = 1'b1;
            wb_ack = n == ack_at;
            wb_dat_i = (n == ack_at && !we) ? smem[adr] : $urandom;
            if (n == ack_at && we) smem[adr] = dat;
            @(negedge clk);
        end
        wb_ack = 1'b0;
        check("stb_cycles", 32'(n), 32'(exp_n));
        check("bus_stable", 32'(bad), 32'd0);
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("cmd_ready_resp", 32'(cmd_ready), 32'd0);
        check("rsp_err", 32'(rsp_err), 32'(!hit));
        check("rsp_dat", rsp_dat, exp_d);
        held_d = rsp_dat; held_e = rsp_err;
        for (int i = 0; i < rdly; i++) begin
            cmd_valid = 1'b1; cmd_we = 1'($urandom); cmd_adr = 8'($urandom); cmd_dat = $urandom;
            wb_ack = 1'($urandom); wb_dat_i = $urandom;
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_no_accept", {30'd0, cmd_ready, wb_stb}, 32'd0);
            check("hold_dat", rsp_dat, held_d);
            check("hold_err", 32'(rsp_err), 32'(held_e));
        end
        cmd_valid = 1'b0; wb_ack = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("after_valid", 32'(rsp_valid), 32'd0);
        check("after_ready", 32'(cmd_ready), 32'd1);
        check("after_stb", 32'(wb_stb), 32'd0);
        check("after_dat", rsp_dat, held_d);
        check("after_err", 32'(rsp_err), 32'(held_e));
    endtask

    initial begin
        int acks [9] = '{1, 2, 3, 5, 15, 16, 17, 0, 2};
        for (int i = 0; i < 256; i++) begin
            smem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A00_0000;
            model[i] = smem[i];
        end
        smem[8'h10] = 32'h0000_00A5;
        model[8'h10] = 32'h0000_00A5;
        #1;
        check("rst_outputs", {25'd0, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, cmd_ready, 1'b0}, 32'h2);
        check("rst_rsp_dat", rsp_dat, 32'h0);
        check("rst_wb_adr_dat", {24'd0, wb_adr} | wb_dat_o, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        txn(1'b0, 8'h10, 32'h0, 2, 0);
        txn(1'b1, 8'h04, 32'h1234_5678, 2, 0);
        txn(1'b0, 8'h04, 32'h0, 1, 0);
        txn(1'b0, 8'h20, 32'h0, 0, 0);
        txn(1'b0, 8'h10, 32'h0, 16, 0);
        txn(1'b1, 8'h30, 32'hDEAD_BEEF, 17, 1);
        txn(1'b0, 8'h30, 32'h0, 3, 5);

        // reset in the middle of a bus cycle
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 8'h55; cmd_dat = 32'hCAFE_F00D;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_stb", 32'(wb_stb), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_bus", {25'd0, wb_cyc, wb_stb, wb_we, rsp_valid, rsp_err, cmd_ready, 1'b0}, 32'h2);
        check("rst_mid_adr_dat", {24'd0, wb_adr} | wb_dat_o | rsp_dat, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wb_ack = 1'b1; wb_dat_i = $urandom;
            @(negedge clk);
            check("spurious_ack", {29'd0, rsp_valid, wb_stb, cmd_ready}, 32'd1);
        end
        wb_ack = 1'b0;
        check("spurious_dat", rsp_dat, 32'h0);
        txn(1'b0, 8'h55, 32'h0, 2, 0);

        for (int k = 0; k < 40; k++)
            txn(1'($urandom), 8'($urandom_range(0, 15)), $urandom,
                acks[$urandom_range(0, 8)], $urandom_range(0, 3));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
